// File: rtl/imem_scan_loader.sv
// Scan-chain front end for instruction memory: deserialises a 64-bit header plus data words into
// IMEM writes, or fetches IMEM words and serialises them onto scan_out.
module imem_scan_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
  output logic              imem_we,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              core_hold,
  output logic              load_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WR, S_RD_REQ, S_RD_CAP, S_RD_SHIFT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [62:0]         hdr_q, hdr_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [30:0]         n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d, re_q, re_d, so_q, so_d, hold_q, hold_d, done_q, done_d;

  logic [63:0]         hdr_full;
  logic [DATA_W-1:0]   word;
  logic [30:0]         n_dec;
  logic [ADDR_W-1:0]   addr_inc;

  always_comb begin
    hdr_full = {scan_in, hdr_q};
    word     = {scan_in, sr_q[DATA_W-1:1]};
    n_dec    = n_q - 31'd1;
    addr_inc = addr_q + ADDR_W'(4);

    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    hdr_d   = hdr_q;
    sr_d    = sr_q;
    n_d     = n_q;
    addr_d  = addr_q;
    iaddr_d = iaddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    so_d    = 1'b0;
    done_d  = 1'b0;
    hold_d  = scan_en | (state_q != S_IDLE);

    if (!scan_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          hdr_d   = {scan_in, hdr_q[62:1]};
          cnt_d   = 6'd1;
          state_d = S_HDR;
        end
        S_HDR: begin
          hdr_d = {scan_in, hdr_q[62:1]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            n_d    = hdr_full[31:1];
            addr_d = ADDR_W'(hdr_full[63:32]);
            bit_d  = '0;
            if (hdr_full[31:1] == 31'd0) begin
              state_d = S_DONE;
            end else if (hdr_full[0]) begin
              state_d = S_WR;
            end else begin
              // Strobe is registered, so it is raised on entry to RD_REQ.
              state_d = S_RD_REQ;
              re_d    = 1'b1;
              iaddr_d = ADDR_W'(hdr_full[63:32]);
            end
          end
        end
        S_WR: begin
          sr_d  = word;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            we_d    = 1'b1;
            iaddr_d = addr_q;
            wdata_d = word;
            addr_d  = addr_inc;
            n_d     = n_dec;
            if (n_dec == 31'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_RD_REQ: state_d = S_RD_CAP;
        S_RD_CAP: begin
          sr_d    = {1'b0, imem_rdata[DATA_W-1:1]};
          so_d    = imem_rdata[0];
          bit_d   = '0;
          state_d = S_RD_SHIFT;
        end
        S_RD_SHIFT: begin
          if (bit_q == 5'd31) begin
            bit_d  = '0;
            addr_d = addr_inc;
            n_d    = n_dec;
            if (n_dec == 31'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RD_REQ;
              re_d    = 1'b1;
              iaddr_d = addr_inc;
            end
          end else begin
            so_d  = sr_q[0];
            sr_d  = {1'b0, sr_q[DATA_W-1:1]};
            bit_d = bit_q + 5'd1;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hdr_q   <= '0;
      sr_q    <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      iaddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      so_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hdr_q   <= hdr_d;
      sr_q    <= sr_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      iaddr_q <= iaddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      so_q    <= so_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign scan_out   = so_q;
  assign imem_we    = we_q;
  assign imem_re    = re_q;
  assign imem_addr  = iaddr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;

endmodule

// File: tb/tb_imem_scan_loader.sv
// Directed bench: stimulus pushes expected IMEM writes/reads into queues, a negedge monitor
// pops them as the DUT strobes and reassembles scan_out words.
module tb_imem_scan_loader;
  logic        clk = 1'b0;
  logic        Rst, scan_en, scan_in;
  logic        scan_out, imem_we, imem_re, core_hold, load_done;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;

  imem_scan_loader #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .Rst(Rst), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .imem_we(imem_we), .imem_re(imem_re), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .core_hold(core_hold), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_wr[$];
  exp_t        exp_rd[$];
  int          checks = 0, errors = 0;
  int          n_done = 0, n_we = 0, n_re = 0;
  logic [31:0] mem [0:15];

  always @(posedge clk) if (imem_re) imem_rdata <= mem[imem_addr[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        rd_active = 1'b0;
  int          rd_phase = 0;
  logic [31:0] rd_word;
  exp_t        rd_cur, wr_cur;

  always @(negedge clk) begin
    if (Rst === 1'b1) begin
      if (load_done) n_done++;
      if (rd_active) begin
        rd_phase++;
        if (rd_phase >= 2 && rd_phase <= 33) rd_word[rd_phase-2] = scan_out;
        if (rd_phase == 33) chk("rd_word", rd_word, rd_cur.data);
        if (rd_phase == 34) begin
          chk("rd_done_pulse", {31'd0, load_done}, {31'd0, rd_cur.last});
          chk("rd_spacing", {31'd0, imem_re}, {31'd0, ~rd_cur.last});
          rd_active = 1'b0;
        end
      end
      if (imem_re) begin
        n_re++;
        chk("re_exclusive", {31'd0, imem_we}, 32'd0);
        if (rd_active) begin
          checks++; errors++;
          $display("FAIL rd_early: re at phase %0d", rd_phase);
        end
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: addr %h", imem_addr);
        end else begin
          rd_cur = exp_rd.pop_front();
          chk("rd_addr", imem_addr, rd_cur.addr);
          rd_active = 1'b1;
          rd_phase  = 0;
          rd_word   = '0;
        end
      end
      if (imem_we) begin
        n_we++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: addr %h data %h", imem_addr, imem_wdata);
        end else begin
          wr_cur = exp_wr.pop_front();
          chk("wr_addr", imem_addr, wr_cur.addr);
          chk("wr_data", imem_wdata, wr_cur.data);
          chk("wr_done", {31'd0, load_done}, {31'd0, wr_cur.last});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    tick();
  endtask

  task automatic send_hdr(input logic op, input logic [30:0] n, input logic [31:0] a);
    logic [63:0] h;
    h = {a, n, op};
    for (int i = 0; i < 64; i++) send_bit(h[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) send_bit(w[i]);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic last);
    exp_t e;
    e.addr = a; e.data = d; e.last = last;
    exp_wr.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input logic last);
    exp_t e;
    e.addr = a; e.data = d; e.last = last;
    exp_rd.push_back(e);
  endtask

  task automatic idle(input int k);
    scan_en = 1'b0;
    scan_in = 1'b0;
    for (int i = 0; i < k; i++) tick();
  endtask

  logic [31:0] burst [0:7];
  int          d0, w0, r0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst[0] = 32'h00012117; burst[1] = 32'h04010113; burst[2] = 32'h00022517;
    burst[3] = 32'h03c50513; burst[4] = 32'h2f5000ef; burst[5] = 32'h00000097;
    burst[6] = 32'h00c08093; burst[7] = 32'h008000ef;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;
    mem[0] = 32'hA5A5_0F0F;
    mem[1] = 32'h1234_5678;
    imem_rdata = '0;
    Rst = 1'b0; scan_en = 1'b0; scan_in = 1'b0;

    // Reset held while scan_en toggles; the last reset cycle has scan_en=1, scan_in=1
    for (int i = 0; i < 5; i++) begin
      scan_en = (i % 2 == 0);
      scan_in = 1'b1;
      tick();
      chk("rst_scan_out", {31'd0, scan_out}, 32'd0);
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_re", {31'd0, imem_re}, 32'd0);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_hold", {31'd0, core_hold}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
    end
    Rst = 1'b1;

    // Write burst with maximal count, ended by scan_en falling
    d0 = n_done;
    for (int i = 0; i < 8; i++) push_wr(32'(i * 4), burst[i], 1'b0);
    send_hdr(1'b1, 31'h7FFF_FFFF, 32'h0);
    chk("hold_burst", {31'd0, core_hold}, 32'd1);
    for (int i = 0; i < 8; i++) send_word(burst[i]);
    scan_en = 1'b0; scan_in = 1'b0;
    tick();
    chk("hold_after_fall1", {31'd0, core_hold}, 32'd1);
    tick();
    chk("hold_after_fall2", {31'd0, core_hold}, 32'd0);
    idle(2);
    chk("burst_pending", exp_wr.size(), 32'd0);
    chk("burst_no_done", n_done - d0, 32'd0);

    // Exact count: third word must be ignored
    d0 = n_done;
    push_wr(32'h100, 32'hCAFE_0001, 1'b0);
    push_wr(32'h104, 32'hCAFE_0002, 1'b1);
    send_hdr(1'b1, 31'd2, 32'h100);
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    send_word(32'hCAFE_0003);
    idle(3);
    chk("exact_pending", exp_wr.size(), 32'd0);
    chk("exact_done_cnt", n_done - d0, 32'd1);

    // Abort mid-word, then a fresh header
    d0 = n_done; w0 = n_we;
    push_wr(32'h0, 32'h1111_2222, 1'b0);
    send_hdr(1'b1, 31'd4, 32'h0);
    send_word(32'h1111_2222);
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    idle(3);
    chk("abort_writes", n_we - w0, 32'd1);
    chk("abort_done", n_done - d0, 32'd0);
    chk("abort_hold", {31'd0, core_hold}, 32'd0);
    push_wr(32'h40, 32'h89AB_CDEF, 1'b1);
    send_hdr(1'b1, 31'd1, 32'h40);
    send_word(32'h89AB_CDEF);
    idle(3);
    chk("fresh_pending", exp_wr.size(), 32'd0);
    chk("fresh_done", n_done - d0, 32'd1);

    // Read back two words
    d0 = n_done; w0 = n_we;
    push_rd(32'h0, 32'hA5A5_0F0F, 1'b0);
    push_rd(32'h4, 32'h1234_5678, 1'b1);
    send_hdr(1'b0, 31'd2, 32'h0);
    for (int i = 0; i < 76; i++) send_bit(1'($urandom_range(0, 1)));
    idle(3);
    chk("rd_pending", exp_rd.size(), 32'd0);
    chk("rd_active_end", {31'd0, rd_active}, 32'd0);
    chk("rd_no_we", n_we - w0, 32'd0);
    chk("rd_done_cnt", n_done - d0, 32'd1);

    // N=0: no access for either op, DONE holds the core
    w0 = n_we; r0 = n_re;
    send_hdr(1'b1, 31'd0, 32'h0);
    send_word(32'hFFFF_FFFF);
    chk("n0_hold", {31'd0, core_hold}, 32'd1);
    idle(3);
    send_hdr(1'b0, 31'd0, 32'h0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    idle(3);
    chk("n0_no_we", n_we - w0, 32'd0);
    chk("n0_no_re", n_re - r0, 32'd0);

    // Address wrap
    push_wr(32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0);
    push_wr(32'h0000_0000, 32'h600D_CAFE, 1'b1);
    send_hdr(1'b1, 31'd2, 32'hFFFF_FFFC);
    send_word(32'h0BAD_F00D);
    send_word(32'h600D_CAFE);
    idle(4);
    chk("wrap_pending", exp_wr.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_scan_loader.md
# imem_scan_loader

Scan-chain front end for instruction memory. Deserialises the serial stream on `scan_in` (header, then data words, LSB first) while `scan_en` is high, and issues word writes into the IMEM port; in read mode it fetches IMEM words and serialises them onto `scan_out`. It sits between the top-level scan pins and the IMEM write/read port inside `rv_uart_top`, and holds the core while a load is in progress.

## Interface
- `ADDR_W`, default 32: width of the IMEM byte address.
- `DATA_W`, default 32: word width. Fixed at 32; other values are unsupported.
- `clk`  in  1: the single clock, which is also used as the scan clock. Every scan bit is sampled on the rising edge of `clk`.
- `Rst`  in  1: reset, synchronous and active-low.
- `scan_en`  in  1: scan session enable. The session is active while this is high.
- `scan_in`  in  1: serial input, LSB first.
- `scan_out`  out  1: serial output in read mode; 0 at all other times.
- `imem_we`  out  1: one-cycle IMEM write strobe.
- `imem_re`  out  1: one-cycle IMEM read strobe.
- `imem_addr`  out  ADDR_W: IMEM byte address.
- `imem_wdata`  out  32: IMEM write data.
- `imem_rdata`  in  32: IMEM read data, valid on the cycle after `imem_re`.
- `core_hold`  out  1: stalls the core while loading.
- `load_done`  out  1: one-cycle pulse when the word count is exhausted.

## Operation
- Header is 64 bits, LSB first:
  - bit 0 = op (1 = write to IMEM, 0 = read from IMEM);
  - bits 1..31 = word count N, 31 bits;
  - bits 32..63 = start byte address A.
- States and transitions:
  - IDLE → HDR on any cycle with `scan_en`=1. The bit sampled in that same cycle is header bit 0.
  - HDR: a 6-bit counter collects 64 bits. Then:
    - N=0 → DONE, no access is made;
    - op=1 → WR;
    - op=0 → RD_REQ.
  - WR: a 32-bit shift register fills LSB first; a 5-bit counter tracks bits. On the 32nd bit:
    - next cycle `imem_we`=1 with `imem_addr`=current address and `imem_wdata`=the word;
    - address += 4, N -= 1;
    - if N reaches 0, go to DONE and pulse `load_done` with the final `imem_we`; otherwise stay in WR.
    - Shifting is continuous with no stall: the next word's bit 0 may be sampled in the same cycle the write strobe is high.
  - RD_REQ: `imem_re`=1 for one cycle at the current address → RD_CAP.
  - RD_CAP: capture `imem_rdata` → RD_SHIFT.
  - RD_SHIFT: drives the captured word on `scan_out`, LSB first, for 32 cycles. Then:
    - address += 4, N -= 1;
    - N=0 → DONE with `load_done` pulse; otherwise → RD_REQ.
    - `scan_in` is ignored in read mode.
  - DONE: ignores `scan_in` and holds until `scan_en`=0 → IDLE.
- `scan_en`=0 in any state → IDLE on the next edge. A partial word or header is discarded, with no write and no `load_done`.
- The address wraps modulo 2^ADDR_W. N=0x7FFF_FFFF is legal; the session then normally ends by `scan_en` falling.

## Timing
- Reset (`Rst`=0 at a rising edge) has the following effects:
  - state is IDLE and all counters are cleared;
  - `scan_out`, `imem_we`, `imem_re`, `load_done`, `core_hold` = 0;
  - `imem_addr` and `imem_wdata` = 0.
- Reset takes priority over everything and aborts a session mid-operation.
- All outputs are registered.
- `core_hold` is registered and equals 1 in the cycle after any edge where `scan_en`=1 or state≠IDLE. It clears one cycle after returning to IDLE.
- Write latency: the last data bit is sampled at edge k; `imem_we` is high during cycle k+1 only.
- Read cadence: 34 cycles per word (1 request, 1 capture, 32 shift). `scan_out` carries bit i during the i-th shift cycle.
- Exactly one write per 32 data bits. No write ever happens in HDR, RD_*, or DONE.
- `imem_we` and `imem_re` are never high simultaneously.

## Test plan
- Reset: hold `Rst`=0 for 5 cycles while `scan_en`=1 toggles. All outputs must be 0. Release reset; the first header bit is sampled only after release.
- Write burst: header op=1, N=0x7FFF_FFFF, A=0, then words 0x00012117, 0x04010113, 0x00022517, 0x03c50513, 0x2f5000ef, 0x00000097, 0x00c08093, 0x008000ef, then drop `scan_en`.
  - Required: 8 write strobes at addresses 0x00, 0x04, …, 0x1C with exactly those data values, each one cycle after its 32nd bit.
  - No `load_done`; `core_hold` high throughout and low 2 cycles after `scan_en` falls.
- Exact count: op=1, N=2, A=0x100, then 3 words.
  - Required: writes at 0x100 and 0x104; `load_done` pulses once with the second write; the third word is ignored.
- Abort: op=1, N=4, A=0; drop `scan_en` after 20 bits of word 2.
  - Required: only the write for word 1 occurs; state returns to IDLE. A fresh header then works normally.
- Read back: preload IMEM at 0x0 = 0xA5A5_0F0F and 0x4 = 0x1234_5678; send op=0, N=2, A=0.
  - Required: `scan_out` serialises 0xA5A5_0F0F then 0x1234_5678, LSB first, 34-cycle spacing; `load_done` pulses after the last bit; no `imem_we`.
- Edges: N=0 → no IMEM access; DONE is entered after the header. Also A=0xFFFF_FFFC with N=2 → writes at 0xFFFF_FFFC then 0x0000_0000.
